// File: rtl/nms_window_sequencer.sv
// -----------------------------------------------------------------------------
// nms_window_sequencer
//
// Purpose:
//   Turns a raster-order stream of signed corner scores into 3x3 windows and
//   runs non-maximum suppression on each complete window. There is one result
//   for every interior pixel of the frame. The result is tagged with the
//   coordinates of the window centre.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   in_valid/in_ready : pixel handshake (in_sof, in_score travel with it)
//   out_valid/out_ready : result handshake (out_is_corner, out_x, out_y)
//   frame_done        : one-cycle pulse after the last pixel of a frame is taken
//   o_dbg_state       : FSM state (0 = FILL, 1 = RUN)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Valid never waits on ready. Payload is held while valid is high
// and ready is low.
//
// Also contains NonmaxSuppression, the window comparator. The centre is a
// corner when it is at least THRESHOLD and strictly greater than every
// neighbour.
// -----------------------------------------------------------------------------
module NonmaxSuppression #(
  parameter int WINDOW_WIDTH  = 3,
  parameter int WINDOW_HEIGHT = 3,
  parameter int DATA_BITS     = 8,
  parameter int THRESHOLD     = 0
) (
  input  logic [WINDOW_WIDTH*WINDOW_HEIGHT*DATA_BITS-1:0] i_window,
  output logic                                            o_is_corner
);
  localparam int N      = WINDOW_WIDTH * WINDOW_HEIGHT;
  localparam int CENTRE = (WINDOW_HEIGHT / 2) * WINDOW_WIDTH + WINDOW_WIDTH / 2;
  localparam logic signed [DATA_BITS-1:0] THR = DATA_BITS'(THRESHOLD);

  logic signed [DATA_BITS-1:0] w_centre;

  always_comb begin
    w_centre    = $signed(i_window[CENTRE*DATA_BITS +: DATA_BITS]);
    o_is_corner = (w_centre >= THR);
    for (int i = 0; i < N; i++) begin
      if (i != CENTRE && !(w_centre > $signed(i_window[i*DATA_BITS +: DATA_BITS])))
        o_is_corner = 1'b0;
    end
  end
endmodule

module nms_window_sequencer #(
  parameter int DATA_BITS    = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int THRESHOLD    = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic                              in_sof,
  input  logic signed [DATA_BITS-1:0]       in_score,
  output logic                              in_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_is_corner,
  output logic [$clog2(IMAGE_WIDTH)-1:0]    out_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]   out_y,
  output logic                              frame_done,
  output logic                              o_dbg_state
);
  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);

  typedef enum logic {ST_FILL = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                      r_state, w_state_next;
  logic [XW-1:0]               r_x, w_cx, w_x_next, r_pend_x;
  logic [YW-1:0]               r_y, w_cy, w_y_next, r_pend_y;
  logic                        r_pending, w_pending_next;
  logic                        w_accept, w_load, w_full, w_last, w_is_corner;
  logic signed [DATA_BITS-1:0] r_lb1 [IMAGE_WIDTH];  // row y-1
  logic signed [DATA_BITS-1:0] r_lb2 [IMAGE_WIDTH];  // row y-2
  logic signed [DATA_BITS-1:0] r_win [3][3];         // [row][col], col 2 newest
  logic [9*DATA_BITS-1:0]      w_win_flat;

  // Single-entry output: a new pixel may enter whenever the output slot is
  // empty or is being drained on this edge.
  assign in_ready    = !out_valid || out_ready;
  assign o_dbg_state = r_state;

  always_comb begin
    // Reset wins over a simultaneous accept, so the pixel is dropped.
    w_accept = in_valid && in_ready && !rst;
    // A pending window moves to the output under the same condition that
    // opens the input, so the window is never overwritten before it is used.
    w_load   = r_pending && in_ready;
    // A start-of-frame pixel is (0,0) whatever the counters say.
    w_cx     = in_sof ? '0 : r_x;
    w_cy     = in_sof ? '0 : r_y;
    w_full   = (w_cx >= X_TWO) && (w_cy >= Y_TWO);
    w_last   = (w_cx == X_LAST) && (w_cy == Y_LAST);
    w_x_next = w_cx + XW'(1);
    w_y_next = w_cy;
    if (w_cx == X_LAST) begin
      w_x_next = '0;
      w_y_next = (w_cy == Y_LAST) ? '0 : w_cy + YW'(1);
    end
    w_state_next   = r_state;
    w_pending_next = r_pending && !in_ready;
    if (w_accept) begin
      w_state_next   = w_full ? ST_RUN : ST_FILL;
      w_pending_next = w_full;
    end
  end

  always_comb begin
    w_win_flat = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w_win_flat[(r*3+c)*DATA_BITS +: DATA_BITS] = r_win[r][c];
  end

  NonmaxSuppression #(
    .WINDOW_WIDTH (3),
    .WINDOW_HEIGHT(3),
    .DATA_BITS    (DATA_BITS),
    .THRESHOLD    (THRESHOLD)
  ) u_nms (
    .i_window   (w_win_flat),
    .o_is_corner(w_is_corner)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending     <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_pend_x      <= '0;
      r_pend_y      <= '0;
      out_valid     <= 1'b0;
      out_is_corner <= 1'b0;
      out_x         <= '0;
      out_y         <= '0;
      frame_done    <= 1'b0;
    end else begin
      r_pending  <= w_pending_next;
      frame_done <= w_accept && w_last;
      if (w_accept) begin
        r_x      <= w_x_next;
        r_y      <= w_y_next;
        r_pend_x <= w_cx - XW'(1);
        r_pend_y <= w_cy - YW'(1);
      end
      if (w_load) begin
        out_valid     <= 1'b1;
        out_is_corner <= w_is_corner;
        out_x         <= r_pend_x;
        out_y         <= r_pend_y;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Datapath storage has no reset. Each entry is rewritten before a
  // complete window can read it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb2[w_cx] <= r_lb1[w_cx];
      r_lb1[w_cx] <= in_score;
      // Clear the older columns at the start of a row so that no window
      // ever mixes two rows.
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= (w_cx == '0) ? '0 : r_win[r][1];
        r_win[r][1] <= (w_cx == '0) ? '0 : r_win[r][2];
      end
      r_win[0][2] <= r_lb2[w_cx];
      r_win[1][2] <= r_lb1[w_cx];
      r_win[2][2] <= in_score;
    end
  end
endmodule

// File: tb/tb_nms_window_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nms_window_sequencer
//
// Purpose:
//   Self-checking bench for nms_window_sequencer. The DUT is set to a 4x4
//   image with 3-bit scores and THRESHOLD 0.
//
// The reference model keeps the current frame as a plain 2-D image. Whenever
// the model accepts a pixel with x>=2 and y>=2, it looks at the 3x3
// neighbourhood centred on (x-1,y-1) and queues {corner, x-1, y-1}.
// -----------------------------------------------------------------------------
module tb_nms_window_sequencer;
  localparam int DB  = 3;
  localparam int IW  = 4;
  localparam int IH  = 4;
  localparam int THR = 0;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid, in_sof, in_ready;
  logic signed [DB-1:0] in_score;
  logic                 out_valid, out_ready, out_is_corner, frame_done, dbg_state;
  logic [1:0]           out_x, out_y;

  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] exp_q[$];
  logic [4:0] got_q[$];
  int         fd_count, exp_fd;
  int         mx, my;
  int         img[IH][IW];
  logic       stop_rand;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  nms_window_sequencer #(
    .DATA_BITS(DB), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .THRESHOLD(THR)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_score(in_score), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_is_corner(out_is_corner), .out_x(out_x),
    .out_y(out_y), .frame_done(frame_done), .o_dbg_state(dbg_state)
  );

  // Capture every result transfer and every frame_done cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back({out_is_corner, out_x, out_y});
      if (frame_done) fd_count++;
    end
  end

  // ---------------- reference model ----------------
  task automatic model_accept(input int s, input logic sof);
    logic corner;
    if (sof) begin mx = 0; my = 0; end
    img[my][mx] = s;
    if (mx >= 2 && my >= 2) begin
      corner = (img[my-1][mx-1] >= THR);
      for (int r = my - 2; r <= my; r++)
        for (int c = mx - 2; c <= mx; c++)
          if (!(r == my - 1 && c == mx - 1) && img[r][c] >= img[my-1][mx-1]) corner = 1'b0;
      exp_q.push_back({corner, 2'(mx - 1), 2'(my - 1)});
    end
    if (mx == IW - 1 && my == IH - 1) exp_fd++;
    mx++;
    if (mx == IW) begin
      mx = 0;
      my++;
      if (my == IH) my = 0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_pixel(input int sc, input logic sof);
    int t = 0;
    logic done = 1'b0;
    in_valid = 1'b1;
    in_score = DB'(sc);
    in_sof   = sof;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
        model_accept(sc, sof);
      end else begin
        t++;
        if (t > 200) begin
          n_vec++; n_err++;
          $display("FAIL accept_timeout: in_ready stayed %b for %0d cycles, required 1", in_ready, t);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'($urandom);
    in_score = DB'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_sof   = 1'($urandom);
      in_score = DB'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((got_q.size() < exp_q.size() || out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic begin_case();
    exp_q.delete();
    got_q.delete();
    fd_count = 0;
    exp_fd   = 0;
  endtask

  function automatic int rnd_score();
    return int'($urandom_range(0, 7)) - 4;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_score = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mx = 0; my = 0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    n_vec++; if ({out_is_corner, out_x, out_y} !== 5'b0) begin n_err++; $display("FAIL rst_out_fields: got %b, required 00000", {out_is_corner, out_x, out_y}); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done: got %b, required 0", frame_done); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL rst_state: got %b, required 0 (FILL)", dbg_state); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_frame();
    begin_case();
    for (int i = 0; i < 11; i++) send_pixel(0, i == 0);
    // Pixel (2,2) has just been taken; its result must appear one edge later.
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: out_valid %b, required 0", out_valid); end
    n_vec++; if (dbg_state !== 1'b1) begin n_err++; $display("FAIL state_run: got %b, required 1 (RUN)", dbg_state); end
    @(negedge clk);
    n_vec++; if ({out_valid, out_x, out_y} !== 5'b10101) begin n_err++; $display("FAIL latency_first: valid/x/y %b, required 10101", {out_valid, out_x, out_y}); end
    for (int i = 11; i < 16; i++) send_pixel(0, 1'b0);
    wait_drain();
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL zero_count: got %0d results, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL zero_result[%0d]: got %b, required %b", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (fd_count !== 1) begin n_err++; $display("FAIL zero_frame_done: %0d pulse cycles, required 1", fd_count); end
  endtask

  task automatic test_single_peak();
    begin_case();
    for (int i = 0; i < 16; i++) send_pixel((i == 5) ? 3 : 0, i == 0);
    wait_drain();
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL peak_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL peak_result[%0d]: got %b, required %b", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 0) begin
      n_vec++; if (got_q[0] !== 5'b10101) begin n_err++; $display("FAIL peak_at_1_1: got %b, required 10101", got_q[0]); end
    end
  endtask

  task automatic test_backpressure();
    begin_case();
    fork
      begin
        for (int i = 0; i < 16; i++) send_pixel(rnd_score(), i == 0);
      end
      begin
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 300) begin @(negedge clk); t++; end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_first_timeout: out_valid %b, required 1", out_valid); end
        @(posedge clk); #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n_vec++;
          if ({in_ready, out_valid, out_is_corner, out_x, out_y} !== {2'b01, exp_q[1]}) begin
            n_err++;
            $display("FAIL bp_stall[%0d]: ready/valid/fields %b, required %b", k,
                     {in_ready, out_valid, out_is_corner, out_x, out_y}, {2'b01, exp_q[1]});
          end
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL bp_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_result[%0d]: got %b, required %b", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (fd_count !== exp_fd) begin n_err++; $display("FAIL bp_frame_done: %0d, required %0d", fd_count, exp_fd); end
  endtask

  task automatic test_mid_sof();
    begin_case();
    for (int i = 0; i < 9; i++) send_pixel(rnd_score(), i == 0);
    for (int i = 0; i < 16; i++) send_pixel(rnd_score(), i == 0);
    wait_drain();
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL sof_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL sof_result[%0d]: got %b, required %b", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 0) begin
      n_vec++; if (got_q[0][3:0] !== 4'b0101) begin n_err++; $display("FAIL sof_first_xy: got %b, required 0101", got_q[0][3:0]); end
    end
    n_vec++; if (fd_count !== 1) begin n_err++; $display("FAIL sof_frame_done: %0d, required 1", fd_count); end
  endtask

  task automatic test_rst_collision();
    begin_case();
    for (int i = 0; i < 6; i++) send_pixel(rnd_score(), i == 0);
    rst = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_score = DB'($urandom);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    mx = 0; my = 0;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstc_out_valid: got %b, required 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstc_in_ready: got %b, required 1", in_ready); end
    // No sof: the frame must line up with the counters cleared by reset.
    for (int i = 0; i < 16; i++) send_pixel(rnd_score(), 1'b0);
    wait_drain();
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rstc_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rstc_result[%0d]: got %b, required %b", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (fd_count !== 1) begin n_err++; $display("FAIL rstc_frame_done: %0d, required 1", fd_count); end
  endtask

  task automatic test_neg_frame();
    begin_case();
    for (int i = 0; i < 16; i++) send_pixel((i == 10) ? 0 : -1, i == 0);
    wait_drain();
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL neg_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL neg_result[%0d]: got %b, required %b", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 3) begin
      n_vec++; if (got_q[3] !== 5'b11010) begin n_err++; $display("FAIL neg_at_2_2: got %b, required 11010", got_q[3]); end
    end
  endtask

  task automatic test_random();
    begin_case();
    stop_rand = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++)
          for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 2));
            send_pixel(rnd_score(), i == 0);
          end
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_result[%0d]: got %b, required %b", i, got_q[i], exp_q[i]); end
    end
    n_vec++; if (fd_count !== exp_fd) begin n_err++; $display("FAIL rand_frame_done: %0d, required %0d", fd_count, exp_fd); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_score = '0; out_ready = 1'b1;
    fd_count = 0; exp_fd = 0; mx = 0; my = 0; stop_rand = 1'b0;
    test_reset();
    test_zero_frame();
    test_single_peak();
    test_backpressure();
    test_mid_sof();
    test_rst_collision();
    test_neg_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
